// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the shared-ALU datapath.
// The master (control unit) reads the IR fields and ALU zero flag and drives every mux select and write enable.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       pc_write;
  logic       ir_write;
  logic       mem_write;
  logic       mdr_write;
  logic       reg_write;
  logic       ab_write;
  logic       alu_out_write;
  logic       epc_write;
  logic       iord;
  logic [1:0] pc_source;
  logic       reg_dst;
  logic       mem_to_reg;

  modport master (
    input  opcode, funct, alu_zero,
    output alu_src_a, alu_src_b, alu_op, pc_write, ir_write, mem_write, mdr_write,
           reg_write, ab_write, alu_out_write, epc_write, iord, pc_source, reg_dst, mem_to_reg
  );

  modport slave (
    output opcode, funct, alu_zero,
    input  alu_src_a, alu_src_b, alu_op, pc_write, ir_write, mem_write, mdr_write,
           reg_write, ab_write, alu_out_write, epc_write, iord, pc_source, reg_dst, mem_to_reg
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: one instruction phase per state, Moore outputs except
// the branch PC write, with a wait counter stretching fetch and load-read to MEM_LAT cycles.
module mc_control_fsm #(
  parameter int unsigned MEM_LAT        = 1,
  parameter logic [1:0]  EXC_VECTOR_SEL = 2'b11
) (
  input  logic               clk,
  input  logic               reset_n,
  mc_control_fsm_if.master   bus,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_WB_ALU    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_EXCEPT    = 4'd12
  } state_t;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       rdst_reg, rdst_next;
  logic       last_wait;
  logic [2:0] r_alu_op;
  logic       r_valid;

  assign last_wait = (cnt_reg == 3'(MEM_LAT - 1));
  assign state     = state_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_RESET;
      cnt_reg   <= 3'd0;
      rdst_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdst_reg  <= rdst_next;
    end
  end

  // Counter restarts whenever a state is entered, so it only advances while a wait state holds.
  assign cnt_next = (state_next == state_reg) ? cnt_reg + 3'd1 : 3'd0;

  always_comb begin
    r_alu_op = ALU_IDLE;
    r_valid  = 1'b1;
    case (bus.funct)
      6'h20:   r_alu_op = ALU_ADD;
      6'h22:   r_alu_op = ALU_SUB;
      6'h24:   r_alu_op = ALU_AND;
      6'h25:   r_alu_op = ALU_OR;
      6'h2A:   r_alu_op = ALU_SLT;
      default: r_valid  = 1'b0;
    endcase
  end

  always_comb begin
    state_next        = state_reg;
    rdst_next         = rdst_reg;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = ALU_IDLE;
    bus.pc_write      = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mdr_write     = 1'b0;
    bus.reg_write     = 1'b0;
    bus.ab_write      = 1'b0;
    bus.alu_out_write = 1'b0;
    bus.epc_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.pc_source     = 2'b00;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;

    case (state_reg)
      S_RESET: state_next = S_FETCH;

      S_FETCH: begin
        bus.alu_src_b = 2'b01;
        bus.alu_op    = ALU_ADD;
        if (last_wait) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_next   = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculatively compute the branch target while registers are read.
        bus.ab_write      = 1'b1;
        bus.alu_src_b     = 2'b11;
        bus.alu_op        = ALU_ADD;
        bus.alu_out_write = 1'b1;
        case (bus.opcode)
          OP_RTYPE:       state_next = S_EXEC_R;
          OP_ADDI:        state_next = S_EXEC_I;
          OP_LW, OP_SW:   state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_J:           state_next = S_JUMP;
          default:        state_next = S_EXCEPT;
        endcase
      end

      S_EXEC_R: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b00;
        if (r_valid) begin
          bus.alu_op        = r_alu_op;
          bus.alu_out_write = 1'b1;
          rdst_next         = 1'b1;
          state_next        = S_WB_ALU;
        end else begin
          state_next = S_EXCEPT;
        end
      end

      S_EXEC_I: begin
        bus.alu_src_a     = 2'b01;
        bus.alu_src_b     = 2'b10;
        bus.alu_op        = ALU_ADD;
        bus.alu_out_write = 1'b1;
        rdst_next         = 1'b0;
        state_next        = S_WB_ALU;
      end

      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = rdst_reg;
        state_next    = S_FETCH;
      end

      S_MEM_ADDR: begin
        bus.alu_src_a     = 2'b01;
        bus.alu_src_b     = 2'b10;
        bus.alu_op        = ALU_ADD;
        bus.alu_out_write = 1'b1;
        state_next        = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        bus.iord = 1'b1;
        if (last_wait) begin
          bus.mdr_write = 1'b1;
          state_next    = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_next     = S_FETCH;
      end

      S_MEM_WRITE: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        state_next    = S_FETCH;
      end

      S_BRANCH: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b00;
        bus.alu_op    = ALU_SUB;
        bus.pc_source = 2'b01;
        bus.pc_write  = (bus.opcode == OP_BNE) ? ~bus.alu_zero : bus.alu_zero;
        state_next    = S_FETCH;
      end

      S_JUMP: begin
        bus.pc_source = 2'b10;
        bus.pc_write  = 1'b1;
        state_next    = S_FETCH;
      end

      S_EXCEPT: begin
        bus.epc_write = 1'b1;
        bus.pc_source = EXC_VECTOR_SEL;
        bus.pc_write  = 1'b1;
        state_next    = S_FETCH;
      end

      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected output records are queued per
// instruction and compared each cycle on the falling edge, for MEM_LAT=1 and MEM_LAT=3 instances.
module tb_mc_control_fsm;

  typedef struct packed {
    logic [3:0] state;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       mdr_write;
    logic       reg_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       epc_write;
    logic       iord;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] state1, state3;
  rec_t       obs1, obs3;
  rec_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;

  mc_control_fsm_if if1();
  mc_control_fsm_if if3();

  mc_control_fsm #(.MEM_LAT(1), .EXC_VECTOR_SEL(2'b11)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1), .state(state1)
  );
  mc_control_fsm #(.MEM_LAT(3), .EXC_VECTOR_SEL(2'b11)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(if3), .state(state3)
  );

  always #5 clk = ~clk;

  assign obs1 = {state1, if1.alu_src_a, if1.alu_src_b, if1.alu_op, if1.pc_write, if1.ir_write,
                 if1.mem_write, if1.mdr_write, if1.reg_write, if1.ab_write, if1.alu_out_write,
                 if1.epc_write, if1.iord, if1.pc_source, if1.reg_dst, if1.mem_to_reg};
  assign obs3 = {state3, if3.alu_src_a, if3.alu_src_b, if3.alu_op, if3.pc_write, if3.ir_write,
                 if3.mem_write, if3.mdr_write, if3.reg_write, if3.ab_write, if3.alu_out_write,
                 if3.epc_write, if3.iord, if3.pc_source, if3.reg_dst, if3.mem_to_reg};

  function automatic rec_t obs(input int sel);
    return (sel == 3) ? obs3 : obs1;
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push_exc();
    rec_t r;
    r = '0; r.state = 4'd12; r.epc_write = 1'b1; r.pc_source = 2'b11; r.pc_write = 1'b1;
    exp_q.push_back(r);
  endtask

  // Expected cycle-by-cycle trace of one instruction, starting at its first FETCH cycle.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int lat);
    rec_t r;
    for (int i = 0; i < lat; i++) begin
      r = '0; r.state = 4'd1; r.src_b = 2'b01; r.alu_op = 3'b001;
      r.ir_write = (i == lat - 1); r.pc_write = (i == lat - 1);
      exp_q.push_back(r);
    end
    r = '0; r.state = 4'd2; r.ab_write = 1'b1; r.src_b = 2'b11; r.alu_op = 3'b001; r.alu_out_write = 1'b1;
    exp_q.push_back(r);
    case (op)
      6'h00: begin
        r = '0; r.state = 4'd3; r.src_a = 2'b01;
        case (fn)
          6'h20: r.alu_op = 3'b001;
          6'h22: r.alu_op = 3'b010;
          6'h24: r.alu_op = 3'b011;
          6'h25: r.alu_op = 3'b100;
          6'h2A: r.alu_op = 3'b111;
          default: r.alu_op = 3'b000;
        endcase
        if (r.alu_op != 3'b000) begin
          r.alu_out_write = 1'b1;
          exp_q.push_back(r);
          r = '0; r.state = 4'd5; r.reg_write = 1'b1; r.reg_dst = 1'b1;
          exp_q.push_back(r);
        end else begin
          exp_q.push_back(r);
          push_exc();
        end
      end
      6'h08: begin
        r = '0; r.state = 4'd4; r.src_a = 2'b01; r.src_b = 2'b10; r.alu_op = 3'b001; r.alu_out_write = 1'b1;
        exp_q.push_back(r);
        r = '0; r.state = 4'd5; r.reg_write = 1'b1;
        exp_q.push_back(r);
      end
      6'h23, 6'h2B: begin
        r = '0; r.state = 4'd6; r.src_a = 2'b01; r.src_b = 2'b10; r.alu_op = 3'b001; r.alu_out_write = 1'b1;
        exp_q.push_back(r);
        if (op == 6'h23) begin
          for (int i = 0; i < lat; i++) begin
            r = '0; r.state = 4'd7; r.iord = 1'b1; r.mdr_write = (i == lat - 1);
            exp_q.push_back(r);
          end
          r = '0; r.state = 4'd8; r.reg_write = 1'b1; r.mem_to_reg = 1'b1;
          exp_q.push_back(r);
        end else begin
          r = '0; r.state = 4'd9; r.iord = 1'b1; r.mem_write = 1'b1;
          exp_q.push_back(r);
        end
      end
      6'h04, 6'h05: begin
        r = '0; r.state = 4'd10; r.src_a = 2'b01; r.alu_op = 3'b010; r.pc_source = 2'b01;
        r.pc_write = (op == 6'h04) ? z : ~z;
        exp_q.push_back(r);
      end
      6'h02: begin
        r = '0; r.state = 4'd11; r.pc_source = 2'b10; r.pc_write = 1'b1;
        exp_q.push_back(r);
      end
      default: push_exc();
    endcase
  endtask

  task automatic consume(input int sel, input string name, input int n);
    rec_t e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", name, i), obs(sel), e);
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z);
    if1.opcode = op; if1.funct = fn; if1.alu_zero = z;
    if3.opcode = op; if3.funct = fn; if3.alu_zero = z;
  endtask

  // Called on a falling edge while the selected DUT sits in the first FETCH cycle.
  task automatic run_instr(input int sel, input string name, input logic [5:0] op,
                           input logic [5:0] fn, input logic z);
    int n;
    drive(op, fn, z);
    push_instr(op, fn, z, (sel == 3) ? 3 : 1);
    n = exp_q.size();
    consume(sel, name, n);
    $display("txn %-10s dut%0d op=%h funct=%h zero=%0b cycles=%0d", name, sel, op, fn, z, n);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_lat1", obs(1), '0);
    check("reset_lat3", obs(3), '0);
    reset_n = 1'b1;
    check("reset_hold", obs(1), '0);
    @(negedge clk);
  endtask

  initial begin
    drive(6'h00, 6'h20, 1'b0);
    do_reset();

    run_instr(1, "addi",     6'h08, 6'h00, 1'b0);
    run_instr(1, "sub",      6'h00, 6'h22, 1'b0);
    run_instr(1, "bad_fn",   6'h00, 6'h3F, 1'b0);
    run_instr(1, "add",      6'h00, 6'h20, 1'b1);
    run_instr(1, "and",      6'h00, 6'h24, 1'b0);
    run_instr(1, "or",       6'h00, 6'h25, 1'b0);
    run_instr(1, "slt",      6'h00, 6'h2A, 1'b0);
    run_instr(1, "beq_z1",   6'h04, 6'h00, 1'b1);
    run_instr(1, "beq_z0",   6'h04, 6'h00, 1'b0);
    run_instr(1, "bne_z1",   6'h05, 6'h00, 1'b1);
    run_instr(1, "bne_z0",   6'h05, 6'h00, 1'b0);
    run_instr(1, "sw",       6'h2B, 6'h00, 1'b0);
    run_instr(1, "j",        6'h02, 6'h00, 1'b0);
    run_instr(1, "lw",       6'h23, 6'h00, 1'b0);
    run_instr(1, "bad_op",   6'h3F, 6'h00, 1'b0);
    run_instr(1, "addi2",    6'h08, 6'h20, 1'b0);

    do_reset();
    run_instr(3, "lw_lat3",  6'h23, 6'h00, 1'b0);
    run_instr(3, "addi_l3",  6'h08, 6'h00, 1'b0);

    // Interrupt a load while MEM_READ is in its second wait cycle.
    drive(6'h23, 6'h00, 1'b0);
    push_instr(6'h23, 6'h00, 1'b0, 3);
    consume(3, "lw_abort", 6);
    check("mid_read_state", {20'd0, state3}, {20'd0, 4'd7});
    #1 reset_n = 1'b0;
    #1 check("async_reset_l3", obs(3), '0);
    check("async_reset_l1", obs(1), '0);
    exp_q.delete();
    $display("txn %-10s dut3 reset asserted mid MEM_READ", "lw_abort");
    @(negedge clk);
    check("reset_held_l3", obs(3), '0);
    reset_n = 1'b1;
    @(negedge clk);
    run_instr(3, "addi_post", 6'h08, 6'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
